alpha_trim_mean: RTL and testbench

Consumer end of the window sort interface in the modified alpha-trimmed mean filter. It takes one window of DN pixels together with the sort result for that window: a list of original pixel indices in ascending value order. It drops the TRIM smallest and TRIM largest entries, sums the remaining KEEP = DN-2*TRIM pixels one per cycle, and divides by KEEP with round-half-up using a bit-serial restoring divider. It emits one DW-bit filtered pixel per window, with a valid pulse.

---
 rtl/alpha_trim_mean.sv | 183 ++++++++++++++++++
 tb/tb_alpha_trim_mean.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_trim_mean.sv
// Trimmed-mean back end: sums the middle KEEP entries of a sorted window, then
// divides by KEEP with round-half-up using a bit-serial restoring divider.
module alpha_trim_mean #(
    parameter int DN     = 25,
    parameter int DW     = 8,
    parameter int DW_SEQ = $clog2(DN),
    parameter int TRIM   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DW_SEQ*DN-1:0] idx_in,
    input  logic [DW*DN-1:0]     win_in,
    output logic [DW-1:0]        mean_out,
    output logic                 mean_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int KEEP = DN - 2 * TRIM;
    localparam int SW   = DW + $clog2(DN);
    localparam int CW   = $clog2(SW + 1);

    localparam logic [DW_SEQ-1:0] K_FIRST   = DW_SEQ'(TRIM);
    localparam logic [DW_SEQ-1:0] K_LAST    = DW_SEQ'(DN - TRIM - 1);
    localparam logic [SW:0]       DIVISOR   = (SW + 1)'(KEEP);
    localparam logic [SW-1:0]     DIVISOR_N = SW'(KEEP);
    localparam logic [SW-1:0]     HALF      = SW'(KEEP / 2);
    localparam logic [CW-1:0]     DIV_LAST  = CW'(SW - 1);

    if (2 * TRIM >= DN) begin : g_trim_check
        $error("alpha_trim_mean: 2*TRIM must be less than DN");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DW_SEQ*DN-1:0] idx_q, idx_d;
    logic [DW*DN-1:0]     win_q, win_d;
    logic [DW_SEQ-1:0]    k_q, k_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        acc_q, acc_d;
    logic [SW-1:0]        rem_q, rem_d;
    logic [DW-1:0]        mean_q, mean_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 ovr_q, ovr_d;

    logic [DW_SEQ-1:0]    entry_s;
    logic [DW-1:0]        pix_s;
    logic [SW-1:0]        sum_s;
    logic [SW:0]          trial_s;
    logic                 fits_s;
    logic                 load_s;

    // Pixel lookup through sorted entry k; an index >= DN matches no pixel and reads 0.
    always_comb begin
        entry_s = '0;
        pix_s   = '0;
        for (int i = 0; i < DN; i++) begin
            entry_s = (k_q == DW_SEQ'(i)) ? idx_q[i*DW_SEQ +: DW_SEQ] : entry_s;
        end
        for (int p = 0; p < DN; p++) begin
            pix_s = (entry_s == DW_SEQ'(p)) ? win_q[p*DW +: DW] : pix_s;
        end
        sum_s   = acc_q + SW'(pix_s);
        trial_s = {rem_q, acc_q[SW-1]};
        fits_s  = (trial_s >= DIVISOR);
        load_s  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start arriving in DONE chains straight into the next window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ACC;
                else       state_d = S_IDLE;
            end
            S_ACC: begin
                if (k_q == K_LAST) state_d = S_DIV;
                else               state_d = S_ACC;
            end
            S_DIV: begin
                if (cnt_q == DIV_LAST) state_d = S_DONE;
                else                   state_d = S_DIV;
            end
            S_DONE: begin
                if (start) state_d = S_ACC;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values; acc doubles as dividend/quotient shift register.
    always_comb begin
        idx_d   = idx_q;
        win_d   = win_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        valid_d = (state_q == S_DONE);
        mean_d  = (state_q == S_DONE) ? acc_q[DW-1:0] : mean_q;
        busy_d  = (state_d == S_ACC) || (state_d == S_DIV);
        ovr_d   = start && ((state_q == S_ACC) || (state_q == S_DIV));
        if (load_s) begin
            idx_d = idx_in;
            win_d = win_in;
            acc_d = '0;
            k_d   = K_FIRST;
        end else begin
            case (state_q)
                S_ACC: begin
                    k_d = k_q + DW_SEQ'(1);
                    if (k_q == K_LAST) begin
                        acc_d = sum_s + HALF;
                        rem_d = '0;
                        cnt_d = '0;
                    end else begin
                        acc_d = sum_s;
                    end
                end
                S_DIV: begin
                    acc_d = {acc_q[SW-2:0], fits_s};
                    rem_d = fits_s ? (trial_s[SW-1:0] - DIVISOR_N) : trial_s[SW-1:0];
                    cnt_d = cnt_q + CW'(1);
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            win_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            mean_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            win_q   <= win_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mean_q  <= mean_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign mean_out   = mean_q;
    assign mean_valid = valid_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Bench for alpha_trim_mean: directed vector table, hand-written timing
// sequences, and random windows checked against a sort-based reference.
module tb_alpha_trim_mean;

    localparam int DN       = 25;
    localparam int DW       = 8;
    localparam int DW_SEQ   = 5;
    localparam int TRIM     = 4;
    localparam int KEEP     = DN - 2 * TRIM;
    localparam int LAT      = 31;
    localparam int BUSY_CYC = 30;
    localparam int WW       = DW * DN;
    localparam int IW       = DW_SEQ * DN;
    localparam int NVEC     = 10;
    localparam int NRAND    = 30;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] idx_in;
    logic [WW-1:0] win_in;
    logic [DW-1:0] mean_out;
    logic          mean_valid;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         name;
        logic [WW-1:0] win;
        logic [IW-1:0] idx;
        int            exp;
    } vec_t;

    vec_t          vecs[NVEC];
    logic [WW-1:0] w;
    logic [IW-1:0] ix;
    int            lat, val, bcnt, nvalid, sum, hi, tmp, expv;
    int            vals[DN];
    int            ord[DN];
    int            q[$];

    alpha_trim_mean #(.DN(DN), .DW(DW), .DW_SEQ(DW_SEQ), .TRIM(TRIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .idx_in    (idx_in),
        .win_in    (win_in),
        .mean_out  (mean_out),
        .mean_valid(mean_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [IW-1:0] ident_idx();
        logic [IW-1:0] r;
        for (int k = 0; k < DN; k++) r[k*DW_SEQ +: DW_SEQ] = DW_SEQ'(k);
        return r;
    endfunction

    function automatic logic [IW-1:0] rev_idx();
        logic [IW-1:0] r;
        for (int k = 0; k < DN; k++) r[k*DW_SEQ +: DW_SEQ] = DW_SEQ'(DN - 1 - k);
        return r;
    endfunction

    function automatic logic [WW-1:0] const_win(input int v);
        logic [WW-1:0] r;
        for (int p = 0; p < DN; p++) r[p*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [WW-1:0] ramp_win();
        logic [WW-1:0] r;
        for (int p = 0; p < DN; p++) r[p*DW +: DW] = DW'(10 * p);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives a one-cycle start; returns at the falling edge right after the sampling edge.
    task automatic launch(input logic [WW-1:0] wv, input logic [IW-1:0] iv);
        @(negedge clk);
        win_in = wv;
        idx_in = iv;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < DN; p++) win_in[p*DW +: DW] = DW'($urandom);
        for (int k = 0; k < DN; k++) idx_in[k*DW_SEQ +: DW_SEQ] = DW_SEQ'($urandom);
    endtask

    // Counts falling edges until mean_valid (bounded); lat = -1 on timeout.
    task automatic collect(output int l, output int v, output int b);
        l = -1;
        v = -1;
        b = 0;
        for (int c = 0; c <= 40; c++) begin
            if (busy) b++;
            if (mean_valid) begin
                l = c;
                v = int'(mean_out);
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        idx_in = '0;
        win_in = '0;

        vecs[0] = '{"flat100", const_win(100), ident_idx(), 100};
        vecs[1] = '{"ramp_ident", ramp_win(), ident_idx(), 120};
        w = const_win(50); w[12*DW +: DW] = 8'd59;
        vecs[2] = '{"round_up", w, ident_idx(), 51};
        w = const_win(50); w[12*DW +: DW] = 8'd58;
        vecs[3] = '{"round_down", w, ident_idx(), 50};
        vecs[4] = '{"ramp_rev", ramp_win(), rev_idx(), 120};
        w = ramp_win();
        for (int p = 0; p < TRIM; p++) w[p*DW +: DW] = 8'd255;
        for (int p = DN - TRIM; p < DN; p++) w[p*DW +: DW] = 8'd0;
        vecs[5] = '{"trim_extremes", w, ident_idx(), 120};
        ix = ident_idx(); ix[12*DW_SEQ +: DW_SEQ] = 5'd31;
        vecs[6] = '{"idx_out_of_range", const_win(100), ix, 94};
        w = const_win(0); w[7*DW +: DW] = 8'd200;
        for (int k = 0; k < DN; k++) ix[k*DW_SEQ +: DW_SEQ] = 5'd7;
        vecs[7] = '{"dup_index", w, ix, 200};
        vecs[8] = '{"all_max", const_win(255), ident_idx(), 255};
        vecs[9] = '{"all_zero", const_win(0), rev_idx(), 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mean_out", int'(mean_out), 0);
        check("rst_mean_valid", int'(mean_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            launch(vecs[i].win, vecs[i].idx);
            collect(lat, val, bcnt);
            check({vecs[i].name, "_value"}, val, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, LAT);
            check({vecs[i].name, "_busy_cycles"}, bcnt, BUSY_CYC);
            @(negedge clk);
            check({vecs[i].name, "_pulse_end"}, int'(mean_valid), 0);
            check({vecs[i].name, "_hold"}, int'(mean_out), vecs[i].exp);
        end

        // Start while busy: overrun pulse, first result unaffected
        launch(ramp_win(), ident_idx());
        repeat (4) @(negedge clk);
        win_in = const_win(255);
        idx_in = ident_idx();
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ovr_pulse", int'(overrun), 1);
        @(negedge clk);
        check("ovr_clear", int'(overrun), 0);
        check("ovr_busy", int'(busy), 1);
        collect(lat, val, bcnt);
        check("ovr_first_value", val, 120);
        check("ovr_first_latency", lat + 6, LAT);

        // Start in the mean_valid cycle is accepted
        win_in = const_win(100);
        idx_in = ident_idx();
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_overrun", int'(overrun), 0);
        collect(lat, val, bcnt);
        check("b2b_value", val, 100);
        check("b2b_latency", lat, LAT);

        // Start in the DONE cycle is accepted without overrun
        launch(ramp_win(), rev_idx());
        repeat (30) @(negedge clk);
        check("done_busy_low", int'(busy), 0);
        check("done_no_valid_yet", int'(mean_valid), 0);
        win_in = const_win(200);
        idx_in = ident_idx();
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_valid", int'(mean_valid), 1);
        check("done_value", int'(mean_out), 120);
        check("done_no_overrun", int'(overrun), 0);
        check("done_accepted_busy", int'(busy), 1);
        @(negedge clk);
        collect(lat, val, bcnt);
        check("done_next_value", val, 200);
        check("done_next_latency", lat + 1, LAT);

        // Reset in the middle of accumulation
        launch(ramp_win(), ident_idx());
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mean_out", int'(mean_out), 0);
        check("mid_rst_valid", int'(mean_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mean_valid) nvalid++;
        end
        check("mid_rst_no_result", nvalid, 0);
        launch(const_win(77), rev_idx());
        collect(lat, val, bcnt);
        check("post_rst_value", val, 77);
        check("post_rst_latency", lat, LAT);

        // Random windows with a genuine argsort as the index list
        for (int n = 0; n < NRAND; n++) begin
            hi = (n % 3 == 0) ? 3 : ((n % 3 == 1) ? 15 : 255);
            q.delete();
            for (int p = 0; p < DN; p++) begin
                vals[p] = int'($urandom_range(0, hi));
                ord[p]  = p;
                q.push_back(vals[p]);
                w[p*DW +: DW] = DW'(vals[p]);
            end
            for (int i = 1; i < DN; i++) begin
                for (int j = i; j > 0; j--) begin
                    if (vals[ord[j-1]] > vals[ord[j]]) begin
                        tmp      = ord[j];
                        ord[j]   = ord[j-1];
                        ord[j-1] = tmp;
                    end
                end
            end
            for (int k = 0; k < DN; k++) ix[k*DW_SEQ +: DW_SEQ] = DW_SEQ'(ord[k]);
            q.sort();
            sum = 0;
            for (int k = TRIM; k < DN - TRIM; k++) sum += q[k];
            expv = (sum + KEEP / 2) / KEEP;
            launch(w, ix);
            collect(lat, val, bcnt);
            check("rand_value", val, expv);
            check("rand_latency", lat, LAT);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
